encrypt_pipe_keyring: RTL and testbench

//  Parametrised successor to the single-byte XOR/rotate encrypt stage. Applies a per-beat key

---
 rtl/encrypt_pipe_keyring.sv | 131 +++++++++++++
 tb/tb_encrypt_pipe_keyring.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/encrypt_pipe_keyring.sv
// encrypt_pipe_keyring: one-stage valid/ready stream cipher.
// Each accepted beat is XORed with, added to, or has subtracted from it a key
// taken from a rotating key ring. The key advances every rot_freq+1 accepted
// non-bypass beats.
// Optional feature macro: ENC_CHKSUM_EN adds a running XOR checksum of accepted
// input beats on port chksum.
module encrypt_pipe_keyring #(
    parameter int DATA_W   = 8,
    parameter int NUM_KEYS = 4,
    parameter int CNT_W    = 4,
    localparam int IDX_W   = $clog2(NUM_KEYS),
    localparam int NK_W    = $clog2(NUM_KEYS) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_KEYS*DATA_W-1:0] keys,
    input  logic [NK_W-1:0]            num_keys,
    input  logic [CNT_W-1:0]           rot_freq,
    input  logic [1:0]                 mode,
    input  logic                       restart,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [IDX_W-1:0]           key_idx_o
`ifdef ENC_CHKSUM_EN
    ,
    output logic [DATA_W-1:0]          chksum
`endif
);

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_XOR    = 2'b01;
    localparam logic [1:0] MODE_ADD    = 2'b10;

    logic [DATA_W-1:0] key_arr [NUM_KEYS];
    logic [IDX_W-1:0]  key_idx_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic [DATA_W-1:0] xf_data;
    logic [NK_W-1:0]   eff_last;
    logic              accept;
    logic              advance;

    // Unpack the flat key bus into an indexable ring.
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            assign key_arr[gi] = keys[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign in_ready  = !out_valid_reg || out_ready;
    assign accept    = in_valid && in_ready;
    assign advance   = accept && (mode != MODE_BYPASS);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign key_idx_o = key_idx_reg;

    // Index of the last active key: clamp num_keys into the range 1..NUM_KEYS.
    always_comb begin
        eff_last = num_keys - NK_W'(1);
        if (num_keys == '0) begin
            eff_last = '0;
        end else if (num_keys > NK_W'(NUM_KEYS)) begin
            eff_last = NK_W'(NUM_KEYS - 1);
        end
    end

    // Transform the incoming beat with the current key; carries and borrows drop.
    always_comb begin
        xf_data = in_data;
        case (mode)
            MODE_BYPASS: xf_data = in_data;
            MODE_XOR:    xf_data = in_data ^ key_arr[key_idx_reg];
            MODE_ADD:    xf_data = in_data + key_arr[key_idx_reg];
            default:     xf_data = in_data - key_arr[key_idx_reg];
        endcase
    end

    // Output register: load on accept, empty when the held beat is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= xf_data;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Key schedule: restart overrides any advance from a simultaneous beat.
    // An index already beyond a shrunk ring wraps to 0 on its next advance.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            key_idx_reg <= '0;
            cnt_reg     <= '0;
        end else if (advance) begin
            if (cnt_reg == rot_freq) begin
                cnt_reg <= '0;
                if ({1'b0, key_idx_reg} >= eff_last) begin
                    key_idx_reg <= '0;
                end else begin
                    key_idx_reg <= key_idx_reg + IDX_W'(1);
                end
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

`ifdef ENC_CHKSUM_EN
    logic [DATA_W-1:0] chksum_reg;

    // Running XOR of accepted input beats in every mode; restart clears it.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            chksum_reg <= '0;
        end else if (accept) begin
            chksum_reg <= chksum_reg ^ in_data;
        end
    end

    assign chksum = chksum_reg;
`endif

endmodule

// File: tb/tb_encrypt_pipe_keyring.sv
// Directed testbench for encrypt_pipe_keyring with hand-computed expectations.
module tb_encrypt_pipe_keyring;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] keys;
    logic [2:0]  num_keys;
    logic [3:0]  rot_freq;
    logic [1:0]  mode;
    logic        restart;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  key_idx_o;
`ifdef ENC_CHKSUM_EN
    logic [7:0]  chksum;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0] exp2 [8];
    logic [7:0] exp_rf0 [5];

    encrypt_pipe_keyring #(.DATA_W(8), .NUM_KEYS(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .keys      (keys),
        .num_keys  (num_keys),
        .rot_freq  (rot_freq),
        .mode      (mode),
        .restart   (restart),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .key_idx_o (key_idx_o)
`ifdef ENC_CHKSUM_EN
        ,
        .chksum    (chksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_restart();
        in_valid = 1'b0;
        restart  = 1'b1;
        step();
        restart  = 1'b0;
    endtask

    initial begin
        exp2 = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04, 8'h04};
        exp_rf0 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01};
        rst = 1'b1; keys = 32'h04030201; num_keys = 3'd4; rot_freq = 4'd1;
        mode = 2'b01; restart = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        step();

        // 1: reset then idle
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_key_idx", {30'd0, key_idx_o}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 2: xor stream of zeros, key advances every 2 beats
        in_valid = 1'b1; in_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("xor_keyidx_%0d", i), {30'd0, key_idx_o}, (i / 2) % 4);
            step();
            chk($sformatf("xor_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("xor_data_%0d", i), {24'd0, out_data}, {24'd0, exp2[i]});
        end
        in_valid = 1'b0;
        chk("xor_wrap_idx", {30'd0, key_idx_o}, 32'd0);
        step();
        chk("xor_drain", {31'd0, out_valid}, 32'd0);

        // 3: add drops the carry; subtract borrows back
        do_restart();
        mode = 2'b10; in_valid = 1'b1; in_data = 8'hFF;
        step(); chk("add_0", {24'd0, out_data}, 32'h00);
        step(); chk("add_1", {24'd0, out_data}, 32'h00);
        do_restart();
        mode = 2'b11; in_valid = 1'b1; in_data = 8'h00;
        step(); chk("sub_0", {24'd0, out_data}, 32'hFF);
        step(); chk("sub_1", {24'd0, out_data}, 32'hFF);

        // 4: backpressure holds output and freezes schedule
        do_restart();
        mode = 2'b01; in_valid = 1'b1; in_data = 8'h10;
        step(); chk("bp_first", {24'd0, out_data}, 32'h11);
        out_ready = 1'b0; in_data = 8'h20;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("bp_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
            step();
            chk($sformatf("bp_hold_%0d", i), {24'd0, out_data}, 32'h11);
            chk($sformatf("bp_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp_idx_%0d", i), {30'd0, key_idx_o}, 32'd0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        step(); chk("bp_after_0", {24'd0, out_data}, 32'h21);
        chk("bp_after_idx", {30'd0, key_idx_o}, 32'd1);
        in_data = 8'h30;
        step(); chk("bp_after_1", {24'd0, out_data}, 32'h32);
        in_valid = 1'b0;
        step(); chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // 5: restart coincident with 3rd accept, then bypass
        do_restart();
        mode = 2'b01; in_valid = 1'b1; in_data = 8'h00;
        step(); chk("rs_b1", {24'd0, out_data}, 32'h01);
        step(); chk("rs_b2", {24'd0, out_data}, 32'h01);
        restart = 1'b1;
        step(); chk("rs_b3", {24'd0, out_data}, 32'h02);
        chk("rs_b3_valid", {31'd0, out_valid}, 32'd1);
        chk("rs_idx", {30'd0, key_idx_o}, 32'd0);
        restart = 1'b0;
        step(); chk("rs_b4", {24'd0, out_data}, 32'h01);
        mode = 2'b00; in_data = 8'h5A;
        step(); chk("byp_0", {24'd0, out_data}, 32'h5A);
        chk("byp_idx_0", {30'd0, key_idx_o}, 32'd0);
        in_data = 8'hA5;
        step(); chk("byp_1", {24'd0, out_data}, 32'hA5);
        chk("byp_idx_1", {30'd0, key_idx_o}, 32'd0);
        mode = 2'b01; in_data = 8'h00;
        step(); chk("byp_resume", {24'd0, out_data}, 32'h01);
        chk("byp_resume_idx", {30'd0, key_idx_o}, 32'd1);

        // num_keys boundaries: 0 acts as 1, above NUM_KEYS acts as NUM_KEYS
        do_restart();
        num_keys = 3'd0; rot_freq = 4'd0; in_valid = 1'b1;
        step(); chk("nk0_0", {24'd0, out_data}, 32'h01);
        step(); chk("nk0_1", {24'd0, out_data}, 32'h01);
        chk("nk0_idx", {30'd0, key_idx_o}, 32'd0);
        num_keys = 3'd7;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("nk7_%0d", i), {24'd0, out_data}, {24'd0, exp_rf0[i]});
        end
        num_keys = 3'd4; rot_freq = 4'd1;

`ifdef ENC_CHKSUM_EN
        // 6: checksum of accepted inputs
        do_restart();
        in_valid = 1'b1; in_data = 8'h12;
        step(); chk("cks_0", {24'd0, chksum}, 32'h12);
        in_data = 8'h34;
        step(); chk("cks_1", {24'd0, chksum}, 32'h26);
        in_data = 8'h55; restart = 1'b1;
        step(); chk("cks_restart", {24'd0, chksum}, 32'h00);
        restart = 1'b0; in_valid = 1'b0;
        step(); chk("cks_idle", {24'd0, chksum}, 32'h00);
`endif

        // reset mid-transfer drops the held beat
        in_valid = 1'b1; out_ready = 1'b0; in_data = 8'h77;
        step(); chk("midrst_loaded", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0; rst = 1'b1;
        step(); chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_data", {24'd0, out_data}, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
